// File: rtl/mac_ws_pkg.sv
// Shared types and helpers for the weight-stationary MAC PE.
//   prod_width : width of the signed product of two IP_size operands
//                once each is extended by one bit for the signed/unsigned mode.
//   sat_add    : add two sign-extended values and report whether the result
//                leaves the signed op_size range. Also returns the clamped result.
//   sat_max/sat_min : signed op_size limits, returned in a MAX_W container.
// Values are carried in a MAX_W container, so op_size must stay below MAX_W.
package mac_ws_pkg;

   localparam int MAX_W = 64;

   typedef logic [MAX_W-1:0] wide_t;

   typedef struct packed {
      logic  ovf;
      wide_t sum;
      wide_t res;
   } sat_add_t;

   function automatic int prod_width(input int ip_size);
      return 2 * ip_size + 2;
   endfunction

   function automatic wide_t sat_max(input int op_size);
      wide_t m;
      m = '0;
      for (int i = 0; i < MAX_W; i++)
         if (i < op_size - 1) m[i] = 1'b1;
      return m;
   endfunction

   // Upper bits are all ones. Truncating to op_size leaves 100..0.
   function automatic wide_t sat_min(input int op_size);
      return ~sat_max(op_size);
   endfunction

   // a and b must be sign-extended from op_size bits. Bit op_size of the
   // sum is then the true sign of the (op_size+1)-bit result. Overflow
   // means that bit differs from bit op_size-1.
   function automatic sat_add_t sat_add(input wide_t a, input wide_t b, input int op_size);
      sat_add_t   r;
      logic [5:0] top;
      top   = 6'(op_size);
      r.sum = a + b;
      r.ovf = r.sum[top] ^ r.sum[top - 6'd1];
      if (!r.ovf)          r.res = r.sum;
      else if (r.sum[top]) r.res = sat_min(op_size);
      else                 r.res = sat_max(op_size);
      return r;
   endfunction

endpackage

// File: rtl/mac_unit_ws_db_if.sv
// Port bundle of one WS PE.
//   Inputs to the PE : en_in, clr_in, sgn_in, w_load_in, w_swap_in,
//                      x_new, w_new, psum_in
//   Outputs from PE  : en_out, clr_out, sgn_out, w_swap_out, x_old, w_old,
//                      mac_out, mac_valid, ovf_out
// master = the side that drives the PE; slave = the PE itself.
interface mac_unit_ws_db_if #(
   parameter int IP_size = 8,
   parameter int OP_size = 32
);
   logic               en_in, clr_in, sgn_in, w_load_in, w_swap_in;
   logic [IP_size-1:0] x_new, w_new;
   logic [OP_size-1:0] psum_in;
   logic               en_out, clr_out, sgn_out, w_swap_out;
   logic [IP_size-1:0] x_old, w_old;
   logic [OP_size-1:0] mac_out;
   logic               mac_valid, ovf_out;

   modport master (
      output en_in, clr_in, sgn_in, w_load_in, w_swap_in, x_new, w_new, psum_in,
      input  en_out, clr_out, sgn_out, w_swap_out, x_old, w_old, mac_out, mac_valid, ovf_out
   );

   modport slave (
      input  en_in, clr_in, sgn_in, w_load_in, w_swap_in, x_new, w_new, psum_in,
      output en_out, clr_out, sgn_out, w_swap_out, x_old, w_old, mac_out, mac_valid, ovf_out
   );
endinterface

// File: rtl/mac_pipe_delay.sv
// DEPTH-stage register chain with a valid bit per stage.
//   clk, rst (sync, active-high), vld_in/data_in -> vld_out/data_out after DEPTH edges.
// A slot that holds no valid op carries all-zero data, so stale values never
// leak downstream.
module mac_pipe_delay #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vld_in,
   input  logic [WIDTH-1:0] data_in,
   output logic             vld_out,
   output logic [WIDTH-1:0] data_out
);
   logic [DEPTH-1:0]            vld_pipe;
   logic [DEPTH-1:0][WIDTH-1:0] dat;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         dat      <= '0;
      end else begin
         vld_pipe[0] <= vld_in;
         dat[0]      <= vld_in ? data_in : '0;
         for (int i = 1; i < DEPTH; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            dat[i]      <= vld_pipe[i-1] ? dat[i-1] : '0;
         end
      end
   end

   assign vld_out  = vld_pipe[DEPTH-1];
   assign data_out = dat[DEPTH-1];
endmodule

// File: rtl/mac_unit_ws_db.sv
// Weight-stationary PE with double-buffered weight.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of mac_unit_ws_db_if (op controls, operands, weight
//              load/swap in; forwarded controls, weight chain, result out)
// The pipeline has three parts. The input stage captures x, the active weight
// and psum. The product and psum then pass through MUL_STAGES registers. The
// accumulate stage updates mac_out. A shadow weight loads in the background
// and w_swap_in commits it.
module mac_unit_ws_db
   import mac_ws_pkg::*;
#(
   parameter int IP_size        = 8,
   parameter int OP_size        = 32,
   parameter int MUL_STAGES     = 2,
   parameter int CLR_LOAD_FIRST = 1,
   parameter int SATURATE       = 0
) (
   input logic              clk,
   input logic              rst,
   mac_unit_ws_db_if.slave  bus
);
   localparam int PW = prod_width(IP_size);
   localparam int DW = 2 * OP_size + 1;

   if (OP_size < PW || OP_size >= MAX_W || MUL_STAGES < 1) begin : g_bad_params
      $error("mac_unit_ws_db: need 2*IP_size+2 <= OP_size < 64 and MUL_STAGES >= 1");
   end

   logic [IP_size-1:0] w_shadow, w_active;
   logic               s1_v, s1_c, s1_s;
   logic [IP_size-1:0] s1_x, s1_w;
   logic [OP_size-1:0] s1_psum;

   // Weights, input stage and forwarded controls. The op sampled in a swap
   // cycle captures the pre-edge w_active, so it still uses the old weight.
   always_ff @(posedge clk) begin
      if (rst) begin
         w_shadow       <= '0;
         w_active       <= '0;
         bus.w_old      <= '0;
         s1_v           <= 1'b0;
         s1_c           <= 1'b0;
         s1_s           <= 1'b0;
         s1_x           <= '0;
         s1_w           <= '0;
         s1_psum        <= '0;
         bus.en_out     <= 1'b0;
         bus.clr_out    <= 1'b0;
         bus.sgn_out    <= 1'b0;
         bus.w_swap_out <= 1'b0;
         bus.x_old      <= '0;
      end else begin
         if (bus.w_load_in) begin
            w_shadow  <= bus.w_new;
            bus.w_old <= bus.w_new;
         end else begin
            bus.w_old <= w_shadow;
         end
         if (bus.w_swap_in) w_active <= w_shadow;
         s1_v           <= bus.en_in;
         s1_c           <= bus.en_in & bus.clr_in;
         s1_s           <= bus.sgn_in;
         s1_x           <= bus.x_new;
         s1_w           <= w_active;
         s1_psum        <= bus.en_in ? bus.psum_in : '0;
         bus.en_out     <= bus.en_in;
         bus.clr_out    <= bus.en_in & bus.clr_in;
         bus.sgn_out    <= bus.sgn_in;
         bus.w_swap_out <= bus.w_swap_in;
         bus.x_old      <= bus.x_new;
      end
   end

   // The product is exact in PW bits for both signed and unsigned operands.
   logic signed [PW-1:0]      x_ext, w_ext, prod;
   logic signed [OP_size-1:0] addend;

   always_comb begin
      if (s1_s) begin
         x_ext = PW'($signed(s1_x));
         w_ext = PW'($signed(s1_w));
      end else begin
         x_ext = PW'(s1_x);
         w_ext = PW'(s1_w);
      end
      prod   = x_ext * w_ext;
      addend = OP_size'(prod);
   end

   logic               d_v, d_c;
   logic [OP_size-1:0] d_add, d_psum;

   mac_pipe_delay #(.WIDTH(DW), .DEPTH(MUL_STAGES)) u_delay (
      .clk      (clk),
      .rst      (rst),
      .vld_in   (s1_v),
      .data_in  ({s1_c, addend, s1_psum}),
      .vld_out  (d_v),
      .data_out ({d_c, d_add, d_psum})
   );

   sat_add_t r;
   always_comb r = sat_add(MAX_W'($signed(d_add)), MAX_W'($signed(d_psum)), OP_size);

   logic unused_hi;
   assign unused_hi = ^{r.sum[MAX_W-1:OP_size], r.res[MAX_W-1:OP_size]};

   // Accumulate stage. A clear op starts a new column sum and also drops the
   // overflow flag. Otherwise the flag is sticky.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mac_out   <= '0;
         bus.mac_valid <= 1'b0;
         bus.ovf_out   <= 1'b0;
      end else begin
         bus.mac_valid <= d_v;
         if (d_v) begin
            if (d_c) begin
               bus.mac_out <= (CLR_LOAD_FIRST != 0) ? d_add : '0;
               bus.ovf_out <= 1'b0;
            end else begin
               if (r.ovf) bus.ovf_out <= 1'b1;
               bus.mac_out <= (SATURATE != 0) ? r.res[OP_size-1:0] : r.sum[OP_size-1:0];
            end
         end
      end
   end
endmodule

// File: doc/mac_unit_ws_db.md
# mac_unit_ws_db

Weight-stationary processing element with a double-buffered weight, a parametrised multiply pipeline depth, per-operation signed/unsigned mode and optional saturating accumulation. It is the drop-in successor PE for the WS systolic array. The next weight tile loads into a shadow register while the current tile computes. A skewed swap token then commits the new weights without stalling the array.

## Interface
Parameters:
- IP_size, 8, operand width (x, w).
- OP_size, 32, partial-sum width; must be ≥ 2*IP_size+2.
- MUL_STAGES, 2, register stages between the input stage and the accumulate stage; must be ≥ 1.
- CLR_LOAD_FIRST, 1, on a clear op: 1 = load the product, 0 = load zero.
- SATURATE, 0, 1 = clamp the accumulate result to the signed OP_size range.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en_in  in  1  op valid.
- clr_in  in  1  first op of a column sum (qualified by en_in).
- sgn_in  in  1  1 = signed operands, 0 = unsigned (qualified by en_in).
- w_load_in  in  1  shift w_new into the shadow weight.
- w_swap_in  in  1  commit shadow weight to active.
- x_new  in  IP_size  activation.
- w_new  in  IP_size  weight being loaded.
- psum_in  in  OP_size  partial sum from the PE above.
- en_out, clr_out, sgn_out, w_swap_out  out  1  control forwarded to the right neighbour, registered.
- x_old  out  IP_size  x_new delayed 1 cycle.
- w_old  out  IP_size  downward weight chain.
- mac_out  out  OP_size  registered psum out.
- mac_valid  out  1  mac_out updated this cycle.
- ovf_out  out  1  sticky overflow flag.

## Operation
- Weight registers w_shadow and w_active.
  - w_load_in=1: w_shadow←w_new, w_old←w_new.
  - Otherwise w_old←w_shadow.
  - w_swap_in=1: w_active←w_shadow, using the pre-edge value.
  - Load and swap in the same cycle: active takes the old shadow and the shadow takes w_new.
- Stage 1 captures:
  - x_new and w_active, pre-edge value. An op issued in the swap cycle uses the old weight.
  - psum_in (zeroed when !en_in).
  - v=en_in, c=en_in&clr_in, s=sgn_in.
- Forwarding: en_out, clr_out (=en_in&clr_in), sgn_out, w_swap_out and x_old are all 1-cycle registers of the inputs.
- Multiply:
  - Each operand is extended to IP_size+1 bits: sign-extended if s=1, zero-extended if s=0.
  - The signed product is 2*IP_size+2 bits, sign-extended to OP_size as the addend.
  - The product and the psum pass through MUL_STAGES registers. Non-valid slots are forced to 0.
- Accumulate, only when the final-stage v=1:
  - c=1: mac_out←addend if CLR_LOAD_FIRST, else 0. ovf_out←0.
  - c=0: sum=psum+addend computed at OP_size+1 bits. Overflow means the top two bits differ.
  - On overflow: ovf_out←1.
  - On overflow with SATURATE=1: mac_out←+max or −min, by the sign of the OP_size+1 sum. With SATURATE=0: mac_out←sum[OP_size-1:0] (wrap).
  - mac_out holds when v=0.
- mac_valid is the registered final-stage v.

## Timing
- Reset values: every register is 0. That covers w_shadow, w_active, all pipeline stages, all forwarded outputs, mac_out, mac_valid and ovf_out.
- Latency: en_in sampled at edge N gives mac_out/mac_valid at edge N+MUL_STAGES+1, i.e. visible MUL_STAGES+2 cycles after issue. The default is 4, matching the previous WS PE.
- Throughput: one op per cycle. Back-to-back ops, clears and swaps need no bubbles.
- A weight swap at edge N affects only ops sampled at edge N+1 and later. In-flight ops keep their captured weight.
- Reset mid-operation flushes all in-flight ops. No mac_valid pulse follows the reset.
- Loading the shadow register during compute never disturbs w_active or in-flight results.

## Structure
- Package mac_ws_pkg holds:
  - The function computing the product width from IP_size.
  - The sat_add function (sum, overflow, clamped result).
  - Constants for saturation limits derived from OP_size.
- Sub-module mac_pipe_delay: a parametrised-width, DEPTH-stage register chain with valid gating and synchronous reset. It is instantiated for the product and psum path over MUL_STAGES.
- A generate-time assertion checks OP_size ≥ 2*IP_size+2 and MUL_STAGES ≥ 1.

## Test plan
- Load w=3, swap, then en with x=5, psum=10, signed → mac_out=25, mac_valid 4 cycles after issue. Then clr op with x=2 → mac_out=6.
- Unsigned mode, w=0xFF, x=0xFF, psum=0 → 65025. Signed mode with the same bits → 1.
- Compute with w_active=2 while loading shadow=7; swap in the cycle of an op with x=1 → that op yields psum+2, the next op with x=1 yields psum+7.
- SATURATE=1, psum=0x7FFFFFF0, w=127, x=127 → mac_out=0x7FFFFFFF and ovf_out=1, sticky until the next clr op, which clears it. SATURATE=0 → wrapped value, ovf_out=1.
- MUL_STAGES=1 and MUL_STAGES=4 → latency of 3 and 6 cycles. Gapped en_in → mac_out holds between valid pulses.
- Assert rst with 3 ops in flight → all outputs 0 next cycle, no mac_valid afterwards.
